// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch request generator.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } fetch_state_t;

    localparam logic [2:0]  SIZE_WORD        = 3'b010;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adel;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// Two-entry fetch buffer; head is a register so decode never sees a
// combinational path from memory data. Flush dominates push.
module fetch_buf
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    fetch_entry_t slot1;
    logic         do_pop;
    logic         do_push;

    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count != 2'd2) || do_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            slot1 <= '0;
            count <= 2'd0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (count == 2'd0) head <= din;
                    else               slot1 <= din;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head  <= slot1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    // Simultaneous push/pop keeps the count; the new word queues behind slot1 if present.
                    if (count == 2'd1) begin
                        head <= din;
                    end else begin
                        head  <= slot1;
                        slot1 <= din;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/inst_fetch_req.sv
// Instruction fetch request generator on an sram-like port, one word in flight.
// Optional FETCH_ADEL_EN: misaligned PCs produce an address-error entry instead of a request.
module inst_fetch_req
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    output logic        inst_req,
    output logic        inst_wr,
    output logic [2:0]  inst_size,
    output logic [31:0] inst_addr,
    output logic [31:0] inst_wdata,
    input  logic [31:0] inst_rdata,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic        id_adel
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  req_pc;
    logic         discard;
    logic [1:0]   count;
    fetch_entry_t head;
    fetch_entry_t push_entry;
    logic         push;
    logic         pop;
    logic         room;
    logic         fetch_blocked;

    assign inst_wr    = 1'b0;
    assign inst_size  = SIZE_WORD;
    assign inst_wdata = '0;

    assign id_valid = (count != 2'd0);
    assign id_pc    = head.pc;
    assign id_inst  = head.inst;
    // Only ever set when address-error entries are enabled.
    assign id_adel  = head.adel;

    assign pop  = id_valid && id_ready && !redirect_valid;
    assign room = (count != 2'd2) || pop;

`ifdef FETCH_ADEL_EN
    logic adel_halt;
    logic adel_fetch;

    assign fetch_blocked = (pc[1:0] != 2'b00);
    assign adel_fetch    = (state == IDLE) && fetch_blocked && !adel_halt && room;

    // One error entry per bad PC; only a redirect restarts fetch.
    always_ff @(posedge clk) begin
        if (reset)               adel_halt <= 1'b0;
        else if (redirect_valid) adel_halt <= 1'b0;
        else if (adel_fetch)     adel_halt <= 1'b1;
    end
`else
    assign fetch_blocked = 1'b0;
`endif

    always_comb begin
        push            = 1'b0;
        push_entry.pc   = req_pc;
        push_entry.inst = inst_rdata;
        push_entry.adel = 1'b0;
        if (!redirect_valid) begin
            if ((state == WAIT) && inst_data_ok && !discard) begin
                push = 1'b1;
            end
`ifdef FETCH_ADEL_EN
            else if (adel_fetch) begin
                push            = 1'b1;
                push_entry.pc   = pc;
                push_entry.inst = '0;
                push_entry.adel = 1'b1;
            end
`endif
        end
    end

    fetch_buf u_buf (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .din   (push_entry),
        .head  (head),
        .count (count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            req_pc    <= '0;
            discard   <= 1'b0;
            inst_req  <= 1'b0;
            inst_addr <= '0;
        end else begin
            if (redirect_valid) pc <= redirect_pc;
            case (state)
                IDLE: begin
                    if (!redirect_valid && room && !fetch_blocked) begin
                        state     <= REQ;
                        inst_req  <= 1'b1;
                        inst_addr <= pc;
                    end
                end
                REQ: begin
                    if (inst_addr_ok) begin
                        state     <= WAIT;
                        req_pc    <= pc;
                        inst_req  <= 1'b0;
                        inst_addr <= '0;
                        if (redirect_valid) discard <= 1'b1;
                        else                pc      <= pc + 32'd4;
                    end else if (redirect_valid) begin
                        // Address is only captured at addr_ok, so retargeting a held request is safe.
                        inst_addr <= redirect_pc;
                    end
                end
                WAIT: begin
                    if (inst_data_ok) begin
                        state   <= IDLE;
                        discard <= 1'b0;
                    end else if (redirect_valid) begin
                        discard <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    inst_req  <= 1'b0;
                    inst_addr <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch_req.sv
// Bench for inst_fetch_req: directed vector table, corner sequences, random vs queue model.
module tb_inst_fetch_req;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req, inst_wr;
    logic [2:0]  inst_size;
    logic [31:0] inst_addr, inst_wdata, inst_rdata;
    logic        inst_addr_ok, inst_data_ok;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid, id_ready, id_adel;
    logic [31:0] id_pc, id_inst;

    int n_run  = 0;
    int n_fail = 0;

    localparam logic [31:0] B = 32'hBFC0_0000;

    always #5 clk = ~clk;

    inst_fetch_req dut (
        .clk            (clk),
        .reset          (reset),
        .inst_req       (inst_req),
        .inst_wr        (inst_wr),
        .inst_size      (inst_size),
        .inst_addr      (inst_addr),
        .inst_wdata     (inst_wdata),
        .inst_rdata     (inst_rdata),
        .inst_addr_ok   (inst_addr_ok),
        .inst_data_ok   (inst_data_ok),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_pc          (id_pc),
        .id_inst        (id_inst),
        .id_adel        (id_adel)
    );

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1357_2468;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Called at a falling edge: apply inputs for one cycle, return at the next falling edge.
    task automatic drive(input logic rdy, input logic aok, input logic dok, input logic rv,
                         input logic [31:0] rpc, input logic [31:0] rdata);
        id_ready       = rdy;
        inst_addr_ok   = aok;
        inst_data_ok   = dok;
        redirect_valid = rv;
        redirect_pc    = rpc;
        inst_rdata     = rdata;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        chk("rst_req",   inst_req,  0);
        chk("rst_addr",  inst_addr, 0);
        chk("rst_valid", id_valid,  0);
        chk("rst_pc",    id_pc,     0);
        chk("rst_inst",  id_inst,   0);
        chk("rst_adel",  id_adel,   0);
        reset = 1'b0;
    endtask

    // From IDLE: expect a request at addr, serve it zero-wait, expect it at the buffer head.
    task automatic fetch_tail(input string name, input logic [31:0] addr);
        drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        chk({name, "_req"},  inst_req,  1);
        chk({name, "_addr"}, inst_addr, addr);
        drive(1'b1, 1'b1, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b1, 1'b0, '0, mem(addr));
        chk({name, "_valid"}, id_valid, 1);
        chk({name, "_pc"},    id_pc,    addr);
        chk({name, "_inst"},  id_inst,  mem(addr));
    endtask

    typedef struct {
        logic        rdy, aok, dok;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
    } vec_t;

    function automatic vec_t v(input logic rdy, input logic aok, input logic dok,
                               input logic [31:0] rdata, input logic e_req,
                               input logic [31:0] e_addr, input logic e_valid,
                               input logic [31:0] e_pc);
        vec_t r;
        r.rdy = rdy; r.aok = aok; r.dok = dok; r.rdata = rdata;
        r.e_req = e_req; r.e_addr = e_addr; r.e_valid = e_valid; r.e_pc = e_pc;
        return r;
    endfunction

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    vec_t tbl[$];
    ent_t q[$];

    initial begin
        reset          = 1'b1;
        id_ready       = 1'b0;
        inst_addr_ok   = 1'b0;
        inst_data_ok   = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        inst_rdata     = '0;
        @(negedge clk);

        // Zero-wait stream, then a decode stall filling both slots.
        tbl.push_back(v(1, 0, 0, 0,           1, B,        0, 0));
        tbl.push_back(v(1, 1, 0, 0,           0, 0,        0, 0));
        tbl.push_back(v(1, 0, 1, mem(B),      0, 0,        1, B));
        tbl.push_back(v(1, 0, 0, 0,           1, B + 4,    0, 0));
        tbl.push_back(v(1, 1, 0, 0,           0, 0,        0, 0));
        tbl.push_back(v(1, 0, 1, mem(B + 4),  0, 0,        1, B + 4));
        tbl.push_back(v(0, 0, 0, 0,           1, B + 8,    1, B + 4));
        tbl.push_back(v(0, 1, 0, 0,           0, 0,        1, B + 4));
        tbl.push_back(v(0, 0, 1, mem(B + 8),  0, 0,        1, B + 4));
        tbl.push_back(v(0, 0, 0, 0,           0, 0,        1, B + 4));
        tbl.push_back(v(0, 0, 0, 0,           0, 0,        1, B + 4));
        tbl.push_back(v(1, 0, 0, 0,           1, B + 12,   1, B + 8));
        tbl.push_back(v(0, 1, 0, 0,           0, 0,        1, B + 8));
        tbl.push_back(v(1, 0, 1, mem(B + 12), 0, 0,        1, B + 12));
        tbl.push_back(v(1, 0, 0, 0,           1, B + 16,   0, 0));

        do_reset();
        chk("const_wr",    inst_wr,    0);
        chk("const_size",  inst_size,  3'b010);
        chk("const_wdata", inst_wdata, 0);
        foreach (tbl[i]) begin
            drive(tbl[i].rdy, tbl[i].aok, tbl[i].dok, 1'b0, '0, tbl[i].rdata);
            chk($sformatf("tbl%0d_req", i),   inst_req,  tbl[i].e_req);
            chk($sformatf("tbl%0d_addr", i),  inst_addr, tbl[i].e_addr);
            chk($sformatf("tbl%0d_valid", i), id_valid,  tbl[i].e_valid);
            if (tbl[i].e_valid) begin
                chk($sformatf("tbl%0d_pc", i),   id_pc,   tbl[i].e_pc);
                chk($sformatf("tbl%0d_inst", i), id_inst, mem(tbl[i].e_pc));
            end
        end

        // Held request retargeted by a redirect while addr_ok is late.
        do_reset();
        drive(1, 0, 0, 0, '0, '0);
        chk("hold_req0", inst_req, 1);
        chk("hold_addr0", inst_addr, B);
        drive(1, 0, 0, 0, '0, '0);
        drive(1, 0, 0, 1, 32'h8000_1000, '0);
        chk("hold_req2", inst_req, 1);
        chk("hold_addr2", inst_addr, 32'h8000_1000);
        drive(1, 0, 0, 0, '0, '0);
        drive(1, 0, 0, 0, '0, '0);
        chk("hold_req4", inst_req, 1);
        chk("hold_addr4", inst_addr, 32'h8000_1000);
        drive(1, 1, 0, 0, '0, '0);
        chk("hold_acc", inst_req, 0);
        drive(1, 0, 1, 0, '0, mem(32'h8000_1000));
        chk("hold_valid", id_valid, 1);
        chk("hold_pc", id_pc, 32'h8000_1000);
        chk("hold_inst", id_inst, mem(32'h8000_1000));

        // Redirect during WAIT; late data must be dropped.
        do_reset();
        drive(1, 0, 0, 0, '0, '0);
        drive(1, 1, 0, 0, '0, '0);
        drive(1, 0, 0, 1, 32'h8000_2000, '0);
        chk("wrd_valid0", id_valid, 0);
        drive(1, 0, 0, 0, '0, '0);
        drive(1, 0, 0, 0, '0, '0);
        drive(1, 0, 1, 0, '0, 32'hDEAD_BEEF);
        chk("wrd_drop", id_valid, 0);
        chk("wrd_noreq", inst_req, 0);
        fetch_tail("wrd", 32'h8000_2000);

        // Redirect in the data_ok cycle.
        do_reset();
        drive(1, 0, 0, 0, '0, '0);
        drive(1, 1, 0, 0, '0, '0);
        drive(1, 0, 1, 1, 32'h8000_2000, 32'hDEAD_BEEF);
        chk("drd_drop", id_valid, 0);
        chk("drd_noreq", inst_req, 0);
        fetch_tail("drd", 32'h8000_2000);

        // Redirect in the addr_ok cycle.
        do_reset();
        drive(1, 0, 0, 0, '0, '0);
        drive(1, 1, 0, 1, 32'h8000_2000, '0);
        chk("ard_req", inst_req, 0);
        drive(1, 0, 1, 0, '0, 32'hDEAD_BEEF);
        chk("ard_drop", id_valid, 0);
        chk("ard_noreq", inst_req, 0);
        fetch_tail("ard", 32'h8000_2000);

`ifdef FETCH_ADEL_EN
        do_reset();
        drive(0, 0, 0, 1, 32'h8000_0002, '0);
        chk("adel_req0", inst_req, 0);
        drive(0, 0, 0, 0, '0, '0);
        chk("adel_req1", inst_req, 0);
        chk("adel_valid", id_valid, 1);
        chk("adel_flag", id_adel, 1);
        chk("adel_pc", id_pc, 32'h8000_0002);
        chk("adel_inst", id_inst, 0);
        drive(0, 0, 0, 0, '0, '0);
        chk("adel_halt", inst_req, 0);
        drive(1, 0, 0, 1, 32'h8000_0000, '0);
        chk("adel_flush", id_valid, 0);
        fetch_tail("adel", 32'h8000_0000);
`endif

        // Random traffic against a queue model of the expected instruction stream.
        begin
            logic [31:0] mpc, macc, maddr, rpc, rnd, rdata;
            logic        outst, squash, rdy, aok, dok, rv;
            int          age, adly, ddly, pushes;
            do_reset();
            q.delete();
            mpc = B; macc = '0; maddr = '0;
            outst = 0; squash = 0; age = 0; adly = 0; ddly = 0; pushes = 0;
            for (int n = 0; n < 3000; n++) begin
                chk("rnd_valid", id_valid, q.size() != 0);
                if (q.size() != 0) begin
                    chk("rnd_pc",   id_pc,   q[0].pc);
                    chk("rnd_inst", id_inst, q[0].inst);
                    chk("rnd_adel", id_adel, 0);
                end
                if (inst_req) begin
                    chk("rnd_addr", inst_addr, mpc);
                    chk("rnd_one_out", outst, 0);
                end
                if (q.size() == 2 && !outst) chk("rnd_full_noreq", inst_req, 0);

                rdy = ((n % 400) < 60) ? 1'b0 : ($urandom_range(0, 3) != 0);
                rv  = ($urandom_range(0, 19) == 0);
                rnd = $urandom();
                case ($urandom_range(0, 3))
                    0:       rpc = 32'hFFFF_FFFC;
                    1:       rpc = 32'h8000_2000;
                    default: rpc = rnd & 32'hFFFF_FFFC;
                endcase
                aok = inst_req && (age >= adly);
                dok = outst && (age >= ddly);
                if (aok) maddr = inst_addr;
                rdata = dok ? mem(maddr) : $urandom();

                if (q.size() != 0 && rdy) void'(q.pop_front());
                if (aok) begin
                    outst = 1; squash = 0; macc = mpc; mpc = mpc + 32'd4;
                    age = 0; ddly = $urandom_range(0, 3);
                end else if (dok) begin
                    outst = 0;
                    if (!squash) begin
                        q.push_back('{pc: macc, inst: mem(macc)});
                        pushes++;
                    end
                    age = 0; adly = $urandom_range(0, 3);
                end else if (inst_req || outst) begin
                    age++;
                end
                if (rv) begin
                    q.delete();
                    mpc = rpc;
                    if (outst) squash = 1;
                end
                drive(rdy, aok, dok, rv, rpc, rdata);
            end
            chk("rnd_progress", pushes > 100, 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
